// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequencing controller for the 16-bit combinational alu
//
// Owns an 8 x 16-bit register file, accepts one instruction at a time over a
// valid/ready handshake, reads the two source registers into the registered
// alu operand outputs, captures the alu result and writes it back to the
// destination register.  Each instruction walks IDLE -> READ -> EXEC -> WRITE.
// A direct register load is accepted in IDLE and takes priority over an
// instruction offered in the same cycle.
//
// Configuration macro:
//   ALU_SEQ_R0_ZERO_EN  defined   : register 0 is hardwired to 0x0000 (writes
//                                   to index 0 dropped, reads of index 0 = 0)
//                       undefined : register 0 is an ordinary register
//
// Ports:
//   clk                in   clock, all state on the rising edge
//   reset              in   synchronous active-high reset (clears everything)
//   ins_valid          in   instruction offered
//   ins_ready          out  high exactly in IDLE
//   ins_op             in   00 add, 01 sub (rs1-rs2), 10 and, 11 or
//   ins_rd/rs1/rs2     in   destination / source register indices
//   ld_valid           in   direct register load (IDLE only, beats ins_valid)
//   ld_addr, ld_data   in   load target and value
//   alu_op             out  to alu.op  (registered, changes only into EXEC)
//   alu_a, alu_b       out  to alu.i0/i1 (registered, change only into EXEC)
//   alu_o, alu_cout    in   from alu.o / alu.cout
//   done               out  one-cycle pulse while in WRITE
//   res                out  last written result, held until the next WRITE
//   carry              out  add: carry-out, sub: 1 = no borrow
//   dbg_addr           in   combinational register-file read address
//   dbg_data           out  register-file read data
// ---------------------------------------------------------------------------
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        ins_valid,
    output logic        ins_ready,
    input  logic [1:0]  ins_op,
    input  logic [2:0]  ins_rd,
    input  logic [2:0]  ins_rs1,
    input  logic [2:0]  ins_rs2,
    input  logic        ld_valid,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_o,
    input  logic        alu_cout,
    output logic        done,
    output logic [15:0] res,
    output logic        carry,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;

`ifdef ALU_SEQ_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Register 0 is write-protected only in the hardwired-zero build.
    function automatic logic wr_allowed(input logic [2:0] addr);
        return !(R0_ZERO && (addr == 3'd0));
    endfunction

    // Masks the raw storage value so index 0 reads as zero when hardwired.
    function automatic logic [DATA_W-1:0] rd_mask(input logic [2:0]        addr,
                                                  input logic [DATA_W-1:0] raw);
        return (R0_ZERO && (addr == 3'd0)) ? '0 : raw;
    endfunction

    state_t              state_q, state_d;

    // Latched instruction fields
    logic [1:0]          op_q,  op_d;
    logic [2:0]          rd_q,  rd_d;
    logic [2:0]          rs1_q, rs1_d;
    logic [2:0]          rs2_q, rs2_d;

    // Operand registers; these are the alu drive registers themselves, so
    // they only change on the READ->EXEC edge and hold everywhere else.
    logic [DATA_W-1:0]   alu_a_q,  alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,  alu_b_d;
    logic [1:0]          alu_op_q, alu_op_d;

    // Result captured at the end of EXEC
    logic [DATA_W-1:0]   result_q, result_d;
    logic                cout_q,   cout_d;

    // Architectural outputs updated in WRITE
    logic [DATA_W-1:0]   res_q,   res_d;
    logic                carry_q, carry_d;

    // Register file and its single write port
    logic [DATA_W-1:0]   rf_q [NREGS];
    logic                rf_we;
    logic [2:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    logic [DATA_W-1:0]   rs1_val;
    logic [DATA_W-1:0]   rs2_val;

    assign rs1_val  = rd_mask(rs1_q,    rf_q[rs1_q]);
    assign rs2_val  = rd_mask(rs2_q,    rf_q[rs2_q]);
    assign dbg_data = rd_mask(dbg_addr, rf_q[dbg_addr]);

    assign ins_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_WRITE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res       = res_q;
    assign carry     = carry_q;

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        cout_d   = cout_q;
        res_d    = res_q;
        carry_d  = carry_q;
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;

        case (state_q)
            S_IDLE: begin
                // A load wins over an instruction offered in the same cycle;
                // the instruction is simply not accepted and must be held.
                if (ld_valid) begin
                    rf_we = wr_allowed(ld_addr);
                end else if (ins_valid) begin
                    op_d    = ins_op;
                    rd_d    = ins_rd;
                    rs1_d   = ins_rs1;
                    rs2_d   = ins_rs2;
                    state_d = S_READ;
                end
            end

            S_READ: begin
                // Sources are read here, before WRITE, so rd aliasing a
                // source always sees the old value.
                alu_a_d  = rs1_val;
                alu_b_d  = rs2_val;
                alu_op_d = op_q;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                result_d = alu_o;
                cout_d   = alu_cout;
                state_d  = S_WRITE;
            end

            S_WRITE: begin
                rf_we    = wr_allowed(rd_q);
                rf_waddr = rd_q;
                rf_wdata = result_q;
                res_d    = result_q;
                // Logic ops leave the carry flag untouched.
                if (!op_q[1]) begin
                    carry_d = cout_q;
                end
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and instruction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            rd_q    <= 3'd0;
            rs1_q   <= 3'd0;
            rs2_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    // Operand, result and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 2'b00;
            result_q <= '0;
            cout_q   <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq
//
// Contains a combinational alu responder, a transaction-level model of the
// register file / res / carry, directed scenarios with literal expectations,
// and a randomized phase.  A compare process checks dbg_data against the
// model on every falling edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ins_valid;
    logic        ins_ready;
    logic [1:0]  ins_op;
    logic [2:0]  ins_rd, ins_rs1, ins_rs2;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        done;
    logic [15:0] res;
    logic        carry;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

`ifdef ALU_SEQ_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_rd    (ins_rd),
        .ins_rs1   (ins_rs1),
        .ins_rs2   (ins_rs2),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .done      (done),
        .res       (res),
        .carry     (carry),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Combinational alu responder
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00:   {alu_cout, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   begin alu_o = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
            2'b10:   alu_o = alu_a & alu_b;
            default: alu_o = alu_a | alu_b;
        endcase
    end

    // Reference model
    logic [15:0] m_rf [8];
    logic [15:0] m_res;
    logic        m_carry;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [15:0] m_read(input logic [2:0] a);
        return (R0Z && a == 3'd0) ? 16'h0000 : m_rf[a];
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [15:0] d);
        if (!(R0Z && a == 3'd0)) m_rf[a] = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_res   = 16'h0000;
        m_carry = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous register-file comparison
    always @(negedge clk) begin
        if (chk_en) chk("dbg_data", {16'h0, dbg_data}, {16'h0, m_read(dbg_addr)});
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        dbg_addr = 3'($urandom);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ins_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        m_clear();
    endtask

    task automatic do_load(input logic [2:0] a, input logic [15:0] d, input bit also_ins);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        if (also_ins) begin
            ins_valid = 1'b1;
            ins_op    = 2'($urandom);
            ins_rd    = 3'($urandom);
            ins_rs1   = 3'($urandom);
            ins_rs2   = 3'($urandom);
        end
        @(negedge clk);
        chk("load_ready", {31'h0, ins_ready}, 32'd1);
        next_cycle();
        ld_valid  = 1'b0;
        ins_valid = 1'b0;
        m_write(a, d);
        if (also_ins) begin
            @(negedge clk);
            chk("ld_prio_ready", {31'h0, ins_ready}, 32'd1);
            chk("ld_prio_done",  {31'h0, done},      32'd0);
            next_cycle();
        end
    endtask

    // abort: 0 none, 1 reset during READ, 2 reset during EXEC
    task automatic do_ins(input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input int abort);
        logic [15:0] a, b, r;
        logic [16:0] s;
        logic        c;
        a = m_read(rs1);
        b = m_read(rs2);
        c = 1'b0;
        case (op)
            2'b00:   begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            2'b01:   begin r = a - b; c = (a >= b); end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        ins_valid = 1'b1;
        ins_op    = op;
        ins_rd    = rd;
        ins_rs1   = rs1;
        ins_rs2   = rs2;
        @(negedge clk);
        chk("accept_ready", {31'h0, ins_ready}, 32'd1);
        chk("accept_done",  {31'h0, done},      32'd0);
        next_cycle();
        for (int k = 1; k <= 3; k++) begin
            // Offers while busy must be ignored
            ins_valid = (k < 3) ? 1'($urandom) : 1'b0;
            ins_op    = 2'($urandom);
            ins_rd    = 3'($urandom);
            ins_rs1   = 3'($urandom);
            ins_rs2   = 3'($urandom);
            if (abort == k) reset = 1'b1;
            @(negedge clk);
            chk("busy_ready", {31'h0, ins_ready}, 32'd0);
            chk("busy_done",  {31'h0, done}, {31'h0, (k == 3)});
            if (k >= 2) begin
                chk("alu_a",  {16'h0, alu_a},  {16'h0, a});
                chk("alu_b",  {16'h0, alu_b},  {16'h0, b});
                chk("alu_op", {30'h0, alu_op}, {30'h0, op});
            end
            next_cycle();
            if (abort == k) begin
                reset     = 1'b0;
                ins_valid = 1'b0;
                m_clear();
                @(negedge clk);
                chk("abort_ready", {31'h0, ins_ready}, 32'd1);
                chk("abort_done",  {31'h0, done},      32'd0);
                chk("abort_res",   {16'h0, res},       32'd0);
                chk("abort_carry", {31'h0, carry},     32'd0);
                chk("abort_alu_a", {16'h0, alu_a},     32'd0);
                chk("abort_alu_op",{30'h0, alu_op},    32'd0);
                next_cycle();
                return;
            end
        end
        ins_valid = 1'b0;
        m_write(rd, r);
        m_res = r;
        if (!op[1]) m_carry = c;
        @(negedge clk);
        chk("post_ready", {31'h0, ins_ready}, 32'd1);
        chk("post_done",  {31'h0, done},      32'd0);
        chk("res",        {16'h0, res},       {16'h0, m_res});
        chk("carry",      {31'h0, carry},     {31'h0, m_carry});
        chk("alu_a_hold", {16'h0, alu_a},     {16'h0, a});
        chk("alu_op_hold",{30'h0, alu_op},    {30'h0, op});
        next_cycle();
    endtask

    // Literal expectation of a register through the debug port
    task automatic chk_reg(input string name, input logic [2:0] a, input logic [15:0] lit);
        dbg_addr = a;
        @(negedge clk);
        chk(name, {16'h0, dbg_data}, {16'h0, lit});
        next_cycle();
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ins_valid = 1'b0;
        ins_op    = 2'b00;
        ins_rd    = 3'd0;
        ins_rs1   = 3'd0;
        ins_rs2   = 3'd0;
        ld_valid  = 1'b0;
        ld_addr   = 3'd0;
        ld_data   = 16'h0;
        dbg_addr  = 3'd0;
        m_clear();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_ready",  {31'h0, ins_ready}, 32'd1);
        chk("rst_done",   {31'h0, done},      32'd0);
        chk("rst_res",    {16'h0, res},       32'd0);
        chk("rst_carry",  {31'h0, carry},     32'd0);
        chk("rst_alu_op", {30'h0, alu_op},    32'd0);
        chk("rst_alu_a",  {16'h0, alu_a},     32'd0);
        chk("rst_alu_b",  {16'h0, alu_b},     32'd0);
        next_cycle();

        // add r3 = r1 + r2
        do_load(3'd1, 16'h1234, 1'b0);
        do_load(3'd2, 16'h0F0F, 1'b0);
        chk_reg("load_visible_r1", 3'd1, 16'h1234);
        do_ins(2'b00, 3'd3, 3'd1, 3'd2, 0);
        chk_reg("t1_r3", 3'd3, 16'h2143);
        chk("t1_carry", {31'h0, carry}, 32'd0);
        chk("t1_res",   {16'h0, res},   32'h2143);

        // Wrapping add then sub with borrow
        do_load(3'd1, 16'hFFFF, 1'b0);
        do_load(3'd2, 16'h0001, 1'b0);
        do_ins(2'b00, 3'd4, 3'd1, 3'd2, 0);
        chk_reg("t2_r4", 3'd4, 16'h0000);
        chk("t2_add_carry", {31'h0, carry}, 32'd1);
        do_ins(2'b01, 3'd5, 3'd2, 3'd1, 0);
        chk_reg("t2_r5", 3'd5, 16'h0002);
        chk("t2_sub_carry", {31'h0, carry}, 32'd0);

        // Logic ops keep carry from the preceding add (which sets it)
        do_load(3'd1, 16'hF0F0, 1'b0);
        do_load(3'd2, 16'h3C3C, 1'b0);
        do_ins(2'b00, 3'd6, 3'd1, 3'd2, 0);
        chk("t3_add_carry", {31'h0, carry}, 32'd1);
        do_ins(2'b10, 3'd6, 3'd1, 3'd2, 0);
        chk_reg("t3_and_r6", 3'd6, 16'h3030);
        do_ins(2'b11, 3'd7, 3'd1, 3'd2, 0);
        chk_reg("t3_or_r7", 3'd7, 16'hFCFC);
        chk("t3_carry_held", {31'h0, carry}, 32'd1);

        // Alias rd == rs1 == rs2
        do_load(3'd1, 16'h0005, 1'b0);
        do_ins(2'b01, 3'd1, 3'd1, 3'd1, 0);
        chk_reg("t4_alias_r1", 3'd1, 16'h0000);
        chk("t4_alias_carry", {31'h0, carry}, 32'd1);

        // Load and instruction together: only the load happens
        do_load(3'd2, 16'hBEEF, 1'b1);
        chk_reg("t4_ld_r2", 3'd2, 16'hBEEF);
        chk_reg("t4_r3_untouched", 3'd3, 16'h2143);

        // Reset during EXEC
        do_ins(2'b00, 3'd3, 3'd1, 3'd2, 2);
        chk_reg("t5_r3_cleared", 3'd3, 16'h0000);

        // Register 0 behaviour
        do_load(3'd0, 16'hAAAA, 1'b0);
        do_ins(2'b00, 3'd1, 3'd0, 3'd0, 0);
        chk_reg("t6_r0", 3'd0, R0Z ? 16'h0000 : 16'hAAAA);
        chk_reg("t6_r1", 3'd1, R0Z ? 16'h0000 : 16'h5554);

        // Randomized phase
        for (int i = 0; i < 250; i++) begin
            int pick;
            pick = $urandom_range(0, 99);
            if (pick < 30) begin
                do_load(3'($urandom), rand_data(), ($urandom_range(0, 9) == 0));
            end else if (pick < 97) begin
                do_ins(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                       ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
            end else begin
                do_reset();
                @(negedge clk);
                chk("rand_rst_res", {16'h0, res}, 32'd0);
                next_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing controller that sits on the operand/result side of the 16-bit `alu` and issues operations to it. It owns an 8-entry × 16-bit register file. It accepts one instruction at a time over a valid/ready handshake, reads two source registers, and drives the ALU's `op`, `i0` and `i1` inputs. It then captures `o`/`cout` and writes the result back to the destination register. It is the initiator for the combinational `alu` responder in the datapath.

## Interface
- Parameters: none (16-bit data, 8 registers fixed to match `alu`).
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ins_valid`  in  1  instruction offered
- `ins_ready`  out  1  controller can accept an instruction (high exactly in IDLE)
- `ins_op`  in  2  00 add, 01 sub (rs1−rs2), 10 and, 11 or
- `ins_rd`, `ins_rs1`, `ins_rs2`  in  3 each  destination and source register indices
- `ld_valid`  in  1  direct register load; accepted only in IDLE, has priority over `ins_valid`
- `ld_addr`  in  3, `ld_data`  in  16  load target and value
- `alu_op`  out  2  to `alu.op`
- `alu_a`, `alu_b`  out  16  to `alu.i0`, `alu.i1`
- `alu_o`  in  16, `alu_cout`  in  1  from `alu.o`, `alu.cout`
- `done`  out  1  one-cycle pulse in the WRITE state
- `res`  out  16  last written result, held until the next WRITE
- `carry`  out  1  carry flag (add: carry-out; sub: 1 = no borrow)
- `dbg_addr`  in  3, `dbg_data`  out  16  combinational register-file read port

## Operation
- The FSM has four states: IDLE → READ → EXEC → WRITE → IDLE.
- **IDLE:** `ins_ready`=1.
  - If `ld_valid`, write `ld_data` to `reg[ld_addr]` at the edge and stay in IDLE. Any `ins_valid` in the same cycle is not accepted.
  - Otherwise, if `ins_valid`, latch op/rd/rs1/rs2 and go to READ.
- **READ:** latch `reg[rs1]` into operand register A and `reg[rs2]` into operand register B.
- **EXEC:** register A drives `alu_a`, register B drives `alu_b`, and the latched op drives `alu_op`. Capture `alu_o` and `alu_cout` into internal result registers at the end of the cycle.
- **WRITE:**
  - Write the captured result to `reg[rd]` and update `res`; pulse `done`=1.
  - Update `carry` from the captured cout only for op 00/01. For op 10/11, `carry` holds its value.
- In every state other than EXEC, `alu_a`, `alu_b` and `alu_op` hold their last values; they are registered and do not toggle outside EXEC.
- `rd` may equal `rs1` and/or `rs2`. Sources are read in READ, before the write in WRITE, so old values are used.
- Arithmetic wraps modulo 2^16; there is no overflow flag. Example: sub 0x0000−0x0001 = 0xFFFF with `carry`=0.
- `ins_valid` while not in IDLE is ignored. The source must hold the instruction until `ins_ready`.

## Timing
- Reset values:
  - state IDLE, so `ins_ready`=1 on the first cycle after reset
  - `done`=0, `res`=0, `carry`=0
  - `alu_op`=00, `alu_a`=0, `alu_b`=0
  - all registers = 0
- Handshake cycle N (`ins_valid`&`ins_ready`): READ at N+1, EXEC at N+2, WRITE at N+3. `done` is high during N+3, the register file is updated at the end of N+3, and `ins_ready` is high again at N+4.
- Throughput: one instruction per 4 cycles. A load takes 1 cycle, and the loaded value is visible on `dbg_data` the next cycle.
- `reset` asserted in any state returns to IDLE at the next edge:
  - the in-flight instruction is discarded with no writeback and no `done`
  - registers are cleared

## Configuration
- `ALU_SEQ_R0_ZERO_EN` defined: register 0 is hardwired to 0x0000.
  - Writes to index 0 by an instruction or a load are dropped.
  - Reads of index 0 return 0.
  - `done`, `res` and `carry` still update normally.
- `ALU_SEQ_R0_ZERO_EN` undefined: register 0 is an ordinary register.

## Test plan
- Reset, then load r1=0x1234 and r2=0x0F0F; issue add r3=r1+r2 → `done` 3 cycles after the accept cycle, r3=0x2143, `carry`=0, `ins_ready` low for exactly 3 cycles.
- Load r1=0xFFFF, r2=0x0001; add r4 → r4=0x0000, `carry`=1. Then sub r5=r2−r1 → r5=0x0002, `carry`=0.
- r1=0xF0F0, r2=0x3C3C: and r6 → 0x3030; or r7 → 0xFCFC. `carry` keeps its value from the preceding add.
- Alias: r1=0x0005, sub r1=r1−r1 → r1=0x0000 with `carry`=1. Simultaneous `ld_valid` and `ins_valid` in IDLE → only the load takes effect.
- Assert `reset` during EXEC of add r3 → no `done`, r3 reads 0, `ins_ready`=1 the next cycle.
- With `ALU_SEQ_R0_ZERO_EN`: load r0=0xAAAA, then add r1=r0+r0 → `dbg_data`(r0)=0, r1=0, `done` pulses.
